reset_sequencer: RTL



---
 rtl/reset_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Ordered multi-domain reset release with button debounce and software request.
// Optional ready-wait timeout is enabled by defining RST_SEQ_TIMEOUT_EN.
module reset_sequencer #(
  parameter int NUM_DOMAINS     = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int GAP_CYCLES      = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_rst_n,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   busy,
  output logic                   seq_done,
  output logic [1:0]             rst_cause,
  output logic                   timeout_err
);

  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DOMAINS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {ASSERT, WAIT_RDY, GAP, DONE} state_t;

  state_t                 state, state_n;
  logic [HW-1:0]          hold_cnt, hold_n;
  logic [GW-1:0]          gap_cnt, gap_n;
  logic [IW-1:0]          idx, idx_n;
  logic [DW-1:0]          deb_cnt, deb_n;
  logic [NUM_DOMAINS-1:0] rstn_n;
  logic [1:0]             cause_n;
  logic                   btn_req;
  logic                   advance;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt, wait_n;
  logic          err_n;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    gap_n   = gap_cnt;
    idx_n   = idx;
    rstn_n  = rst_n_out;
    cause_n = rst_cause;
    deb_n   = deb_cnt;
    advance = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    wait_n  = wait_cnt;
    err_n   = timeout_err;
`endif

    // The debounce count saturates one past the firing point so a held button fires once.
    btn_req = !btn_rst_n && (deb_cnt == DEB_LAST);
    if (btn_rst_n)
      deb_n = '0;
    else if (deb_cnt != DEB_MAX)
      deb_n = deb_cnt + 1'b1;

    case (state)
      ASSERT: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n   = WAIT_RDY;
          hold_n    = '0;
          idx_n     = '0;
          rstn_n    = '0;
          rstn_n[0] = 1'b1;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      WAIT_RDY: begin
`ifdef RST_SEQ_TIMEOUT_EN
        if (domain_ready[idx]) begin
          advance = 1'b1;
          wait_n  = '0;
        end else if (wait_cnt == TMO_LAST) begin
          advance = 1'b1;
          wait_n  = '0;
          err_n   = 1'b1;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
`else
        advance = domain_ready[idx];
`endif
        if (advance) begin
          if (idx == LAST_IDX) begin
            state_n = DONE;
          end else if (GAP_CYCLES == 0) begin
            idx_n         = idx + 1'b1;
            rstn_n[idx_n] = 1'b1;
          end else begin
            state_n = GAP;
            gap_n   = '0;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n       = WAIT_RDY;
          gap_n         = '0;
          idx_n         = idx + 1'b1;
          rstn_n[idx_n] = 1'b1;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = ASSERT;
    endcase

    // Any request overrides whatever the sequence was doing; the button wins the cause.
    if (btn_req || sw_rst_req) begin
      state_n = ASSERT;
      hold_n  = '0;
      gap_n   = '0;
      idx_n   = '0;
      rstn_n  = '0;
      cause_n = btn_req ? CAUSE_BTN : CAUSE_SW;
`ifdef RST_SEQ_TIMEOUT_EN
      wait_n  = '0;
      err_n   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ASSERT;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      idx       <= '0;
      deb_cnt   <= '0;
      rst_n_out <= '0;
      rst_cause <= CAUSE_POR;
`ifdef RST_SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      gap_cnt   <= gap_n;
      idx       <= idx_n;
      deb_cnt   <= deb_n;
      rst_n_out <= rstn_n;
      rst_cause <= cause_n;
`ifdef RST_SEQ_TIMEOUT_EN
      wait_cnt    <= wait_n;
      timeout_err <= err_n;
`endif
    end
  end

  assign busy     = (state != DONE);
  assign seq_done = (state == DONE);

endmodule
